// File: rtl/fifo_in_writer_if.sv
// fifo_in_writer_if: bundles the upstream valid/ready stream, the fifo_in Avalon-MM data
// port and the fifo_in_csr Avalon-MM control port used by fifo_in_writer.
// master = the writer block, slave = the surrounding source/FIFO side.
interface fifo_in_writer_if;
    // Upstream stream
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    // fifo_in data port
    logic [31:0] fifo_in_writedata;
    logic        fifo_in_write;
    logic        fifo_in_waitrequest;
    // fifo_in_csr control port
    logic [2:0]  fifo_in_csr_address;
    logic        fifo_in_csr_read;
    logic [31:0] fifo_in_csr_writedata;
    logic        fifo_in_csr_write;
    logic [31:0] fifo_in_csr_readdata;

    modport master (
        input  s_data,
        input  s_valid,
        output s_ready,
        output fifo_in_writedata,
        output fifo_in_write,
        input  fifo_in_waitrequest,
        output fifo_in_csr_address,
        output fifo_in_csr_read,
        output fifo_in_csr_writedata,
        output fifo_in_csr_write,
        input  fifo_in_csr_readdata
    );

    modport slave (
        output s_data,
        output s_valid,
        input  s_ready,
        input  fifo_in_writedata,
        input  fifo_in_write,
        output fifo_in_waitrequest,
        input  fifo_in_csr_address,
        input  fifo_in_csr_read,
        input  fifo_in_csr_writedata,
        input  fifo_in_csr_write,
        output fifo_in_csr_readdata
    );
endinterface

// File: rtl/fifo_in_writer.sv
// fifo_in_writer: FPGA-side producer for the HPS-bound on-chip FIFO. Moves 32-bit stream
// words onto the fifo_in Avalon-MM port through a single holding register, polls the FIFO
// fill level over fifo_in_csr and throttles the stream before headroom runs out.
// Optional statistics outputs (words_written, stall_cycles): define FIFO_IN_WRITER_STATS_EN.
module fifo_in_writer #(
    parameter int unsigned DEPTH            = 256,
    parameter int unsigned HEADROOM         = 8,
    parameter int unsigned POLL_INTERVAL    = 64,
    parameter int unsigned CSR_READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    fifo_in_writer_if.master       bus,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   throttled
`ifdef FIFO_IN_WRITER_STATS_EN
    ,
    output logic [31:0]            words_written,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned FW     = AW + 1;
    localparam int unsigned EW     = AW + 2;
    localparam int unsigned CntMax = (POLL_INTERVAL > CSR_READ_LATENCY) ?
                                     POLL_INTERVAL : CSR_READ_LATENCY;
    localparam int unsigned CW     = $clog2(CntMax + 1);

    localparam logic [EW-1:0] Threshold = EW'(DEPTH - HEADROOM);
    localparam logic [FW-1:0] SentMax   = FW'(DEPTH);
    localparam logic [CW-1:0] WaitLoad  = CW'(POLL_INTERVAL - 1);
    localparam logic [CW-1:0] LatLoad   = CW'(CSR_READ_LATENCY - 1);

    typedef enum logic [1:0] {StWait, StRead, StLat} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [FW-1:0] sent_q, sent_d;
    logic          thr_q, thr_d;
    logic [EW-1:0] est;
    logic          capture;
    logic          wr_done;
    logic          accept;
    logic          ready;

    // Only the fill_level field of the CSR readdata is meaningful.
    logic unused_rdata;
    assign unused_rdata = ^bus.fifo_in_csr_readdata[31:FW];

    assign wr_done = write_q & ~bus.fifo_in_waitrequest;
    // The holding register frees up in the same cycle the pending write completes.
    assign ready   = enable & ~thr_q & (~write_q | ~bus.fifo_in_waitrequest);
    assign accept  = bus.s_valid & ready;

    assign bus.s_ready               = ready;
    assign bus.fifo_in_write         = write_q;
    assign bus.fifo_in_writedata     = wdata_q;
    assign bus.fifo_in_csr_address   = 3'd0;
    assign bus.fifo_in_csr_writedata = 32'd0;
    assign bus.fifo_in_csr_write     = 1'b0;
    // The FSM resets into READ, so the strobe is held off while reset is asserted.
    assign bus.fifo_in_csr_read      = (state_q == StRead) & ~reset;

    assign fill_level = fill_q;
    assign throttled  = thr_q;

    // Write holding register next state: load on accept, drop after completion.
    always_comb begin
        write_d = write_q;
        wdata_d = wdata_q;
        if (accept) begin
            write_d = 1'b1;
            wdata_d = bus.s_data;
        end else if (wr_done) begin
            write_d = 1'b0;
        end
    end

    // Poll FSM next state: WAIT countdown, one-cycle READ, LAT countdown then capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StRead;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRead: begin
                state_d = StLat;
                cnt_d   = LatLoad;
            end
            StLat: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StRead;
                cnt_d   = '0;
            end
        endcase
    end

    // Occupancy estimate: captured level plus writes completed since the last READ.
    always_comb begin
        sent_d = sent_q;
        if (state_q == StRead) begin
            // A write completing in the READ cycle lands after the sampled level.
            sent_d = FW'(wr_done);
        end else if (wr_done && (sent_q != SentMax)) begin
            sent_d = sent_q + 1'b1;
        end
        fill_d = capture ? bus.fifo_in_csr_readdata[FW-1:0] : fill_q;
        est    = EW'(fill_d) + EW'(sent_d);
        thr_d  = thr_q;
        if (capture || wr_done) begin
            thr_d = (est >= Threshold);
        end
    end

    // State registers; throttled starts set until the first poll has returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRead;
            cnt_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            fill_q  <= '0;
            sent_q  <= '0;
            thr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
            sent_q  <= sent_d;
            thr_q   <= thr_d;
        end
    end

`ifdef FIFO_IN_WRITER_STATS_EN
    logic [31:0] words_q;
    logic [31:0] stalls_q;

    // Completed-write counter (wraps) and stalled-cycle counter (saturates).
    always_ff @(posedge clk) begin
        if (reset) begin
            words_q  <= 32'd0;
            stalls_q <= 32'd0;
        end else begin
            if (wr_done) begin
                words_q <= words_q + 32'd1;
            end
            if (write_q && bus.fifo_in_waitrequest && (stalls_q != 32'hFFFF_FFFF)) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign words_written = words_q;
    assign stall_cycles  = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_in_writer.sv
// tb_fifo_in_writer: directed bench for fifo_in_writer. A cycle table covers reset, the
// first poll and a short stream with a stall; hand-written sequences cover poll spacing,
// continuous streaming, stalls, enable drop, headroom throttling and the stats counters.
module tb_fifo_in_writer;

    localparam int unsigned DEPTH    = 256;
    localparam int unsigned HEADROOM = 8;
    localparam int unsigned POLL     = 16;
    localparam int unsigned LAT      = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [8:0] fill_level;
    logic       throttled;
`ifdef FIFO_IN_WRITER_STATS_EN
    logic [31:0] words_written;
    logic [31:0] stall_cycles;
`endif

    fifo_in_writer_if bus();

    always #5 clk = ~clk;

    fifo_in_writer #(
        .DEPTH            (DEPTH),
        .HEADROOM         (HEADROOM),
        .POLL_INTERVAL    (POLL),
        .CSR_READ_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .fill_level (fill_level),
        .throttled  (throttled)
`ifdef FIFO_IN_WRITER_STATS_EN
        ,
        .words_written (words_written),
        .stall_cycles  (stall_cycles)
`endif
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        vld;
        logic [31:0] data;
        logic        wreq;
        logic [31:0] rdata;
        logic        rdy;
        logic        wr;
        logic [31:0] wd;
        logic        csr;
        logic        thr;
        logic [8:0]  fill;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vt [NVEC];

    int          n_vec = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          stall_seen = 0;
    int          cyc = 0;
    logic [31:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, sample 1 ns later, update the scoreboard.
    task automatic tick(input logic en, input logic vld, input logic [31:0] data,
                        input logic wreq);
        @(negedge clk);
        enable                  = en;
        bus.s_valid             = vld;
        bus.s_data              = data;
        bus.fifo_in_waitrequest = wreq;
        #1;
        cyc++;
        check("write", {31'd0, bus.fifo_in_write}, {31'd0, q.size() != 0});
        if (q.size() != 0) check("writedata", bus.fifo_in_writedata, q[0]);
        if (bus.fifo_in_write && wreq) stall_seen++;
        if (bus.fifo_in_write && !wreq) begin
            void'(q.pop_front());
            n_done++;
        end
        if (vld && bus.s_ready) q.push_back(data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        enable      = 1'b0;
        bus.s_valid = 1'b0;
        bus.fifo_in_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        q.delete();
        n_done     = 0;
        stall_seen = 0;
        check("reset write", {31'd0, bus.fifo_in_write}, 32'd0);
        check("reset fill_level", {23'd0, fill_level}, 32'd0);
        check("reset throttled", {31'd0, throttled}, 32'd1);
        check("reset csr_read", {31'd0, bus.fifo_in_csr_read}, 32'd0);
        reset = 1'b0;
        #1;
        check("post-reset csr_read", {31'd0, bus.fifo_in_csr_read}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   idx, base, d0, thr_at, first_acc, first_wr, run, maxrun, wrcycles;
        logic found, wreq;

        bus.s_valid              = 1'b0;
        bus.s_data               = 32'd0;
        bus.fifo_in_waitrequest  = 1'b0;
        bus.fifo_in_csr_readdata = 32'd0;

        //           rst   en    vld   data           wreq  rdata
        //           rdy   wr    wd             csr   thr   fill
        vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 9'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 9'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h55,
                   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 9'd0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'hFFFF_FE05,
                   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 9'd0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 9'd5};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 32'h0,
                   1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 9'd5};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 32'h0,
                   1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 9'd5};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0,
                   1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 9'd5};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,
                   1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 9'd5};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,
                   1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 9'd5};
        vt[10] = '{1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 9'd5};

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            reset                    = vt[i].rst;
            enable                   = vt[i].en;
            bus.s_valid              = vt[i].vld;
            bus.s_data               = vt[i].data;
            bus.fifo_in_waitrequest  = vt[i].wreq;
            bus.fifo_in_csr_readdata = vt[i].rdata;
            #1;
            check($sformatf("v%0d s_ready", i), {31'd0, bus.s_ready}, {31'd0, vt[i].rdy});
            check($sformatf("v%0d write", i), {31'd0, bus.fifo_in_write}, {31'd0, vt[i].wr});
            check($sformatf("v%0d writedata", i), bus.fifo_in_writedata, vt[i].wd);
            check($sformatf("v%0d csr_read", i), {31'd0, bus.fifo_in_csr_read},
                  {31'd0, vt[i].csr});
            check($sformatf("v%0d throttled", i), {31'd0, throttled}, {31'd0, vt[i].thr});
            check($sformatf("v%0d fill_level", i), {23'd0, fill_level}, {23'd0, vt[i].fill});
            check($sformatf("v%0d csr tie-offs", i),
                  {bus.fifo_in_csr_writedata[28:0], bus.fifo_in_csr_address},
                  {31'd0, bus.fifo_in_csr_write});
        end
        bus.fifo_in_csr_readdata = 32'd0;

        // Poll spacing: next READ 16 WAIT cycles after the capture; period READ+LAT+WAIT.
        found = 1'b0;
        for (int k = 1; k <= 40 && !found; k++) begin
            tick(1'b0, 1'b0, 32'd0, 1'b0);
            if (bus.fifo_in_csr_read) begin
                found = 1'b1;
                check("second poll cycle", k, 10);
            end
        end
        check("second poll seen", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int k = 1; k <= 40 && !found; k++) begin
            tick(1'b0, 1'b0, 32'd0, 1'b0);
            if (k == 1) check("csr_read one cycle", {31'd0, bus.fifo_in_csr_read}, 32'd0);
            if (bus.fifo_in_csr_read) begin
                found = 1'b1;
                check("poll period", k, POLL + LAT + 1);
            end
        end
        check("third poll seen", {31'd0, found}, 32'd1);

        // Continuous stream of 16 words, no waitrequest.
        idx = 0; first_acc = -1; first_wr = -1; run = 0; maxrun = 0; wrcycles = 0;
        base = n_done;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, idx < 16, 32'(idx + 1), 1'b0);
            if (bus.fifo_in_write) begin
                wrcycles++;
                run++;
                if (first_wr < 0) first_wr = k;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (bus.s_valid && bus.s_ready) begin
                if (first_acc < 0) first_acc = k;
                idx++;
            end
        end
        check("stream first write latency", first_wr, first_acc + 1);
        check("stream longest write run", maxrun, 16);
        check("stream write cycles", wrcycles, 16);
        check("stream words done", n_done - base, 16);

        // Five stalled cycles on 0xA5A5A5A5.
        base = n_done;
        tick(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b1, 32'hBBBB_BBBB, 1'b1);
            check("stall s_ready", {31'd0, bus.s_ready}, 32'd0);
        end
        tick(1'b1, 1'b1, 32'hBBBB_BBBB, 1'b0);
        check("stall release s_ready", {31'd0, bus.s_ready}, 32'd1);
        tick(1'b1, 1'b0, 32'd0, 1'b0);
        tick(1'b1, 1'b0, 32'd0, 1'b0);
        check("stall words done", n_done - base, 2);

        // Enable dropped while a write is stalled.
        base = n_done;
        tick(1'b1, 1'b1, 32'hC000_0000, 1'b0);
        tick(1'b0, 1'b1, 32'hC000_0001, 1'b1);
        check("disable stalled s_ready", {31'd0, bus.s_ready}, 32'd0);
        tick(1'b0, 1'b1, 32'hC000_0002, 1'b1);
        tick(1'b0, 1'b1, 32'hC000_0003, 1'b0);
        check("disable complete s_ready", {31'd0, bus.s_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 32'hC000_0004, 1'b0);
            check("disabled s_ready", {31'd0, bus.s_ready}, 32'd0);
        end
        check("disable words done", n_done - base, 1);

        // Headroom throttle: level 240 leaves room for 8 words before the 248 threshold.
        bus.fifo_in_csr_readdata = 32'd240;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(1'b1, 1'b0, 32'd0, 1'b0);
            found = bus.fifo_in_csr_read;
        end
        check("throttle poll seen", {31'd0, found}, 32'd1);
        base = n_done; thr_at = -1;
        for (int k = 0; k < 26; k++) begin
            d0 = n_done;
            tick(1'b1, 1'b1, 32'hD000_0000 + 32'(k), 1'b0);
            if (thr_at < 0 && throttled) begin
                thr_at = k;
                check("writes before throttle", d0 - base, 8);
                bus.fifo_in_csr_readdata = 32'd248;
            end else if (thr_at >= 0) begin
                check("throttled held", {31'd0, throttled}, 32'd1);
                check("throttled s_ready", {31'd0, bus.s_ready}, 32'd0);
            end
        end
        check("throttle cycle", thr_at, 9);
        check("writes through throttle", n_done - base, 9);

        // A poll returning 247 with nothing sent since READ releases the stream.
        bus.fifo_in_csr_readdata = 32'd247;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(1'b1, 1'b1, 32'hE000_0000, 1'b0);
            check("release wait s_ready", {31'd0, bus.s_ready}, 32'd0);
            found = bus.fifo_in_csr_read;
        end
        check("release poll seen", {31'd0, found}, 32'd1);
        tick(1'b1, 1'b1, 32'hE000_0001, 1'b0);
        check("release lat1 throttled", {31'd0, throttled}, 32'd1);
        tick(1'b1, 1'b1, 32'hE000_0002, 1'b0);
        check("release lat2 throttled", {31'd0, throttled}, 32'd1);
        check("release lat2 s_ready", {31'd0, bus.s_ready}, 32'd0);
        tick(1'b1, 1'b1, 32'hE000_0003, 1'b0);
        check("released throttled", {31'd0, throttled}, 32'd0);
        check("released s_ready", {31'd0, bus.s_ready}, 32'd1);
        tick(1'b1, 1'b0, 32'd0, 1'b0);
        tick(1'b1, 1'b0, 32'd0, 1'b0);
        bus.fifo_in_csr_readdata = 32'd0;

`ifdef FIFO_IN_WRITER_STATS_EN
        // 100 writes with exactly 37 stalled cycles, then reset clears both counters.
        do_reset();
        for (int k = 0; k < 20 && throttled; k++) tick(1'b1, 1'b0, 32'd0, 1'b0);
        check("stats unthrottled", {31'd0, throttled}, 32'd0);
        idx = 0;
        for (int k = 0; k < 400 && n_done < 100; k++) begin
            wreq = (stall_seen < 37) && (cyc % 3 == 0);
            tick(1'b1, idx < 100, 32'(idx), wreq);
            if (bus.s_valid && bus.s_ready) idx++;
        end
        tick(1'b1, 1'b0, 32'd0, 1'b0);
        check("words_written", words_written, 32'd100);
        check("stall_cycles", stall_cycles, 32'd37);
        do_reset();
        check("words_written after reset", words_written, 32'd0);
        check("stall_cycles after reset", stall_cycles, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_in_writer.md
Name: fifo_in_writer

Overview:
- FPGA-side producer for the HPS-bound on-chip FIFO.
- Accepts 32-bit words from fabric logic on a valid/ready stream and issues Avalon-MM writes on the FIFO's fifo_in data port, honouring waitrequest.
- Periodically reads the FIFO fill level through the fifo_in_csr port and throttles the upstream stream before the FIFO reaches a headroom threshold.
- Sits between fabric data sources and the soc_system fifo_in/fifo_in_csr ports.

Parameters:
- DEPTH, 256, FIFO depth in words; power of two, 16..4096.
- HEADROOM, 8, free words kept in reserve; throttle threshold is DEPTH-HEADROOM.
- POLL_INTERVAL, 64, cycles between the end of one CSR poll and the start of the next; >=1.
- CSR_READ_LATENCY, 1, cycles from fifo_in_csr_read to valid fifo_in_csr_readdata; 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  0 = accept no new stream words; in-flight write still completes.
- s_data  in  32  upstream word.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  word accepted when s_valid & s_ready.
- fifo_in_writedata  out  32  Avalon write data.
- fifo_in_write  out  1  Avalon write request.
- fifo_in_waitrequest  in  1  FIFO stall.
- fifo_in_csr_address  out  3  fixed at 0 (fill_level register).
- fifo_in_csr_read  out  1  CSR read strobe.
- fifo_in_csr_writedata  out  32  tied 0.
- fifo_in_csr_write  out  1  tied 0.
- fifo_in_csr_readdata  in  32  CSR read data.
- fill_level  out  log2(DEPTH)+1  last captured fill level.
- throttled  out  1  stream blocked by the headroom rule.

Behaviour:
- Reset values:
  - fifo_in_write=0, fifo_in_writedata=0, fifo_in_csr_read=0, fill_level=0.
  - throttled=1; remains 1 until the first poll completes.
  - Poll FSM enters READ on the first cycle after reset deasserts.
- Write path: one output holding register.
  - s_ready = enable & ~throttled & (~fifo_in_write | ~fifo_in_waitrequest). This is combinational on waitrequest.
  - On accept: writedata<=s_data and write<=1 on the next edge; latency 1 cycle.
  - While write & waitrequest: writedata and write hold stable.
  - Write completes on any cycle with write & ~waitrequest. write drops on the next edge unless a new word is accepted that same cycle, giving back-to-back writes at 1 word/cycle.
  - Deasserting enable or asserting throttled never aborts a pending write.
- Poll FSM:
  - WAIT: counter counts POLL_INTERVAL-1 down to 0, then goes to READ.
  - READ: fifo_in_csr_read=1 for exactly one cycle; sent_since clears to 0; go to LAT.
  - LAT: wait CSR_READ_LATENCY cycles; on the final cycle capture readdata[log2(DEPTH):0] into fill_level; go to WAIT.
- Occupancy estimate:
  - sent_since increments on each completed write after the READ cycle, including writes completing in the READ cycle itself. It saturates at DEPTH.
  - est = fill_level + sent_since, computed log2(DEPTH)+2 bits wide with no wrap.
  - throttled is registered: 1 when est >= DEPTH-HEADROOM, else 0. It updates on capture and on every completed write.
  - A completed write and a capture in the same cycle: capture loads fill_level, and sent_since keeps the count including that write.
- readdata bits above log2(DEPTH) are ignored.
- A reset mid-write drops the held word and mid-poll abandons the read; no recovery handshake.

Optional Feature:
- Macro: FIFO_IN_WRITER_STATS_EN.
- Defined:
  - Adds outputs words_written[31:0] (completed writes, wraps at 2^32) and stall_cycles[31:0] (cycles with write & waitrequest, saturates at 0xFFFFFFFF).
  - Both counters clear on reset.
- Undefined: the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset then idle, readdata=0 -> csr_read pulses 1 cycle at the first post-reset cycle; throttled 1->0 after capture; the next poll starts POLL_INTERVAL cycles after capture.
- Stream 0x00000001..0x00000010 continuously, waitrequest=0 -> fifo_in_write high for 16 consecutive cycles, one cycle after the first accept; data in order.
- waitrequest=1 for 5 cycles during word 0xA5A5A5A5 -> writedata stable, s_ready=0 for those 5 cycles, no data lost or duplicated.
- DEPTH=256, HEADROOM=8, readdata=240, stream continuously -> throttled asserts after the 8th completed write post-READ; s_ready=0 afterwards until a poll returns a value below 248 less sent_since.
- enable dropped while a write is stalled -> the pending write completes, then no further writes; s_ready=0.
- With FIFO_IN_WRITER_STATS_EN defined, 100 writes with 37 stall cycles -> words_written=100, stall_cycles=37; reset -> both 0.
